// File: rtl/ecc_mem_ctrl.sv
// ecc_mem_ctrl
//   Drives port A of a dual-port RAM that stores Hamming(12,8) codewords.
//   Host writes are encoded before they reach the RAM. Host reads and background
//   scrub reads are checked and corrected, and single-bit errors are written back.
//   A scrubber walks every address at a fixed interval. It competes with the host
//   for the RAM, and contended grants alternate between the two.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_req/i_we/i_addr   host request, held until o_ack; direction and address
//   i_wdata             host write byte
//   o_ack               one-cycle completion pulse for a host operation
//   o_rdata             corrected read byte, valid with o_ack on reads
//   o_err_corr          with o_ack: single-bit error corrected
//   o_err_uncorr        with o_ack: uncorrectable syndrome, o_rdata is raw
//   i_scrub_en          runs the scrub interval timer
//   o_scrub_busy        a scrub access is in flight
//   o_corr_count        saturating count of corrected words (host + scrub)
//   o_ram_*             RAM port A: enable pulse, write enable, address, codeword
//   i_ram_dout          codeword read from RAM port A
module ecc_mem_ctrl #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 12,
  parameter int READ_LATENCY   = 3,
  parameter int WRITE_LATENCY  = 3,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_wdata,
  output logic                  o_ack,
  output logic [7:0]            o_rdata,
  output logic                  o_err_corr,
  output logic                  o_err_uncorr,
  input  logic                  i_scrub_en,
  output logic                  o_scrub_busy,
  output logic [7:0]            o_corr_count,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  localparam int MAXLAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int LW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam int TW     = $clog2(SCRUB_INTERVAL);

  typedef enum logic [1:0] {ST_IDLE, ST_WR_WAIT, ST_RD_WAIT, ST_WB_WAIT} state_t;

  // Data bits sit at positions 3,5,6,7,9,10,11,12 (bit index = position-1).
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  function automatic logic [7:0] extract(input logic [11:0] c);
    return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic [3:0] syndrome(input logic [11:0] c);
    logic [3:0] s;
    s = '0;
    for (int unsigned k = 0; k < 12; k++)
      if (c[k]) s ^= 4'(k + 1);
    return s;
  endfunction

  state_t                  state, state_n;
  logic [LW-1:0]           cnt, cnt_n;
  logic                    ack_q, ack_n;
  logic [7:0]              rdata_q, rdata_n;
  logic                    corr_q, corr_n;
  logic                    uncorr_q, uncorr_n;
  logic                    en_q, en_n;
  logic                    we_q, we_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   din_q, din_n;
  logic                    cur_scrub, cur_scrub_n;
  logic                    prio_host, prio_host_n;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_n;
  logic [7:0]              count, count_n;
  logic                    grant_scrub;
  logic [TW-1:0]           timer;
  logic                    scrub_pending;

  logic [3:0]              syn;
  logic                    is_corr, is_uncorr;
  logic [11:0]             fixed_word;

  always_comb begin
    syn        = syndrome(i_ram_dout);
    is_corr    = (syn != 4'd0) && (syn <= 4'd12);
    is_uncorr  = (syn >= 4'd13);
    fixed_word = i_ram_dout;
    for (int unsigned k = 0; k < 12; k++)
      if (syn == 4'(k + 1)) fixed_word[k] = ~fixed_word[k];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      corr_q    <= 1'b0;
      uncorr_q  <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      cur_scrub <= 1'b0;
      prio_host <= 1'b0;
      ptr       <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ack_q     <= ack_n;
      rdata_q   <= rdata_n;
      corr_q    <= corr_n;
      uncorr_q  <= uncorr_n;
      en_q      <= en_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      din_q     <= din_n;
      cur_scrub <= cur_scrub_n;
      prio_host <= prio_host_n;
      ptr       <= ptr_n;
      count     <= count_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ack_n       = 1'b0;
    rdata_n     = rdata_q;
    corr_n      = 1'b0;
    uncorr_n    = 1'b0;
    en_n        = 1'b0;
    we_n        = we_q;
    addr_n      = addr_q;
    din_n       = din_q;
    cur_scrub_n = cur_scrub;
    prio_host_n = prio_host;
    ptr_n       = ptr;
    count_n     = count;
    grant_scrub = 1'b0;

    case (state)
      ST_IDLE: begin
        // prio_host flips only on contended grants, so contention alternates
        if (scrub_pending && i_req) prio_host_n = ~prio_host;
        if (scrub_pending && (!i_req || !prio_host)) begin
          grant_scrub = 1'b1;
          en_n        = 1'b1;
          we_n        = 1'b0;
          addr_n      = ptr;
          cur_scrub_n = 1'b1;
          cnt_n       = '0;
          state_n     = ST_RD_WAIT;
        end else if (i_req) begin
          en_n        = 1'b1;
          addr_n      = i_addr;
          cur_scrub_n = 1'b0;
          cnt_n       = '0;
          if (i_we) begin
            we_n    = 1'b1;
            din_n   = encode(i_wdata);
            state_n = ST_WR_WAIT;
          end else begin
            we_n    = 1'b0;
            state_n = ST_RD_WAIT;
          end
        end
      end
      ST_WR_WAIT: begin
        cnt_n = cnt + LW'(1);
        if (cnt == LW'(WRITE_LATENCY - 1)) begin
          ack_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        cnt_n = cnt + LW'(1);
        if (cnt == LW'(READ_LATENCY - 1)) begin
          if (cur_scrub) begin
            ptr_n = ptr + ADDR_WIDTH'(1);
          end else begin
            ack_n    = 1'b1;
            rdata_n  = is_corr ? extract(fixed_word) : extract(i_ram_dout);
            corr_n   = is_corr;
            uncorr_n = is_uncorr;
          end
          if (is_corr) begin
            if (count != 8'hFF) count_n = count + 8'd1;
            // writeback enable becomes visible alongside the host ack
            en_n    = 1'b1;
            we_n    = 1'b1;
            din_n   = fixed_word;
            cnt_n   = '0;
            state_n = ST_WB_WAIT;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_WB_WAIT: begin
        cnt_n = cnt + LW'(1);
        if (cnt == LW'(WRITE_LATENCY - 1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A timer expiry on the same edge as a scrub grant re-arms pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer         <= '0;
      scrub_pending <= 1'b0;
    end else begin
      if (grant_scrub) scrub_pending <= 1'b0;
      if (i_scrub_en) begin
        if (timer == TW'(SCRUB_INTERVAL - 1)) begin
          timer         <= '0;
          scrub_pending <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

  assign o_ack        = ack_q;
  assign o_rdata      = rdata_q;
  assign o_err_corr   = corr_q;
  assign o_err_uncorr = uncorr_q;
  assign o_scrub_busy = cur_scrub && (state != ST_IDLE);
  assign o_corr_count = count;
  assign o_ram_en     = en_q;
  assign o_ram_we     = we_q;
  assign o_ram_addr   = addr_q;
  assign o_ram_din    = din_q;

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed testbench for ecc_mem_ctrl (READ/WRITE latency 3, scrub interval 4).
module tb_ecc_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_addr;
  logic [7:0]  i_wdata;
  logic        o_ack;
  logic [7:0]  o_rdata;
  logic        o_err_corr;
  logic        o_err_uncorr;
  logic        i_scrub_en;
  logic        o_scrub_busy;
  logic [7:0]  o_corr_count;
  logic        o_ram_en;
  logic        o_ram_we;
  logic [2:0]  o_ram_addr;
  logic [11:0] o_ram_din;
  logic [11:0] i_ram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  ecc_mem_ctrl #(
    .ADDR_WIDTH(3), .DATA_WIDTH(12), .READ_LATENCY(3),
    .WRITE_LATENCY(3), .SCRUB_INTERVAL(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ack(o_ack), .o_rdata(o_rdata), .o_err_corr(o_err_corr),
    .o_err_uncorr(o_err_uncorr), .i_scrub_en(i_scrub_en), .o_scrub_busy(o_scrub_busy),
    .o_corr_count(o_corr_count), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One host operation; records the first RAM access and any writeback after it.
  task automatic host_op(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                         output int lat, output int ens,
                         output logic [11:0] din0, output logic we0, output logic [2:0] a0,
                         output logic [11:0] wbd, output logic wbw, output logic [2:0] wba,
                         output logic [7:0] rd, output logic ce, output logic ue);
    bit done;
    lat = 0; ens = 0; done = 0;
    din0 = '0; we0 = 0; a0 = '0; wbd = '0; wbw = 0; wba = '0; rd = '0; ce = 0; ue = 0;
    i_req = 1; i_we = we; i_addr = addr; i_wdata = wd;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (o_ram_en) begin
        if (ens == 0) begin din0 = o_ram_din; we0 = o_ram_we; a0 = o_ram_addr; end
        else begin wbd = o_ram_din; wbw = o_ram_we; wba = o_ram_addr; end
        ens++;
      end
      if (o_ack) begin rd = o_rdata; ce = o_err_corr; ue = o_err_uncorr; done = 1; end
    end
    i_req = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_ram_en) begin
        if (ens == 0) begin din0 = o_ram_din; we0 = o_ram_we; a0 = o_ram_addr; end
        else begin wbd = o_ram_din; wbw = o_ram_we; wba = o_ram_addr; end
        ens++;
      end
    end
  endtask

  int          lat, ens, n, cyc, nacks;
  logic [11:0] din0, wbd;
  logic        we0, wbw, ce, ue, bad_we, busy0, saw_ack, saw_en;
  logic [2:0]  a0, wba;
  logic [7:0]  rd;
  logic [2:0]  addrs [9];
  logic [3:0]  seq;

  initial begin
    rst = 1; i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    i_scrub_en = 0; i_ram_dout = 12'hA5F;
    #1;
    chk("rst_ack", o_ack, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_corr", o_err_corr, 0);
    chk("rst_uncorr", o_err_uncorr, 0);
    chk("rst_busy", o_scrub_busy, 0);
    chk("rst_count", o_corr_count, 0);
    chk("rst_en", o_ram_en, 0);
    chk("rst_we", o_ram_we, 0);
    chk("rst_addr", o_ram_addr, 0);
    chk("rst_din", o_ram_din, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // host write 0xAB @3
    host_op(1, 3'd3, 8'hAB, lat, ens, din0, we0, a0, wbd, wbw, wba, rd, ce, ue);
    chk("wr_lat", lat, 4);
    chk("wr_ens", ens, 1);
    chk("wr_din", din0, 12'hA5F);
    chk("wr_we", we0, 1);
    chk("wr_addr", a0, 3);

    // clean read
    i_ram_dout = 12'hA5F;
    host_op(0, 3'd3, 8'h00, lat, ens, din0, we0, a0, wbd, wbw, wba, rd, ce, ue);
    chk("rd_lat", lat, 4);
    chk("rd_data", rd, 8'hAB);
    chk("rd_ce", ce, 0);
    chk("rd_ue", ue, 0);
    chk("rd_ens", ens, 1);
    chk("rd_we", we0, 0);

    // position 6 flipped
    i_ram_dout = 12'hA7F;
    host_op(0, 3'd3, 8'h00, lat, ens, din0, we0, a0, wbd, wbw, wba, rd, ce, ue);
    chk("c6_lat", lat, 4);
    chk("c6_data", rd, 8'hAB);
    chk("c6_ce", ce, 1);
    chk("c6_ue", ue, 0);
    chk("c6_ens", ens, 2);
    chk("c6_wb_din", wbd, 12'hA5F);
    chk("c6_wb_we", wbw, 1);
    chk("c6_wb_addr", wba, 3);
    chk("c6_count", o_corr_count, 1);

    // syndrome 15: uncorrectable, raw data returned
    i_ram_dout = 12'hB7F;
    host_op(0, 3'd5, 8'h00, lat, ens, din0, we0, a0, wbd, wbw, wba, rd, ce, ue);
    chk("u15_data", rd, 8'hBF);
    chk("u15_ue", ue, 1);
    chk("u15_ce", ce, 0);
    chk("u15_ens", ens, 1);
    chk("u15_count", o_corr_count, 1);

    // syndrome 1 (parity bit)
    i_ram_dout = 12'h001;
    host_op(0, 3'd6, 8'h00, lat, ens, din0, we0, a0, wbd, wbw, wba, rd, ce, ue);
    chk("s1_data", rd, 8'h00);
    chk("s1_ce", ce, 1);
    chk("s1_ens", ens, 2);
    chk("s1_wb_din", wbd, 12'h000);
    chk("s1_count", o_corr_count, 2);

    // syndrome 12: highest correctable position
    i_ram_dout = 12'h800;
    host_op(0, 3'd6, 8'h00, lat, ens, din0, we0, a0, wbd, wbw, wba, rd, ce, ue);
    chk("s12_data", rd, 8'h00);
    chk("s12_ce", ce, 1);
    chk("s12_wb_din", wbd, 12'h000);
    chk("s12_count", o_corr_count, 3);

    // syndrome 13: lowest uncorrectable
    i_ram_dout = 12'h801;
    host_op(0, 3'd6, 8'h00, lat, ens, din0, we0, a0, wbd, wbw, wba, rd, ce, ue);
    chk("s13_data", rd, 8'h80);
    chk("s13_ue", ue, 1);
    chk("s13_ce", ce, 0);
    chk("s13_ens", ens, 1);
    chk("s13_count", o_corr_count, 3);

    // scrubber walks 0..7 then wraps to 0
    i_ram_dout = 12'hA5F;
    i_scrub_en = 1;
    n = 0; cyc = 0; bad_we = 0; busy0 = 0;
    while (n < 9 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (o_ram_en) begin
        addrs[n] = o_ram_addr;
        if (o_ram_we) bad_we = 1;
        if (n == 0) busy0 = o_scrub_busy;
        n++;
      end
    end
    chk("scrub_n", n, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("scrub_addr%0d", i), addrs[i], i % 8);
    chk("scrub_we", bad_we, 0);
    chk("scrub_busy", busy0, 1);
    i_scrub_en = 0;
    repeat (12) @(posedge clk);
    #1;

    // contention with host held high: scrub, host, scrub, host
    i_scrub_en = 1;
    cyc = 0;
    while (!o_scrub_busy && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("cont_busy", o_scrub_busy, 1);
    i_req = 1; i_we = 0; i_addr = 3'd2;
    n = 0; cyc = 0; seq = '0;
    while (n < 4 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (o_ram_en) begin seq = {seq[2:0], o_scrub_busy}; n++; end
    end
    chk("cont_seq", seq, 4'b1010);
    i_req = 0; i_scrub_en = 0;
    repeat (15) @(posedge clk);
    #1;

    // reset in the middle of a read
    i_ram_dout = 12'hA5F;
    i_req = 1; i_we = 0; i_addr = 3'd1;
    @(posedge clk); #1;
    chk("mid_en", o_ram_en, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("mid_rst_en", o_ram_en, 0);
    chk("mid_rst_addr", o_ram_addr, 0);
    chk("mid_rst_din", o_ram_din, 0);
    chk("mid_rst_ack", o_ack, 0);
    chk("mid_rst_rdata", o_rdata, 0);
    chk("mid_rst_count", o_corr_count, 0);
    chk("mid_rst_busy", o_scrub_busy, 0);
    i_req = 0;
    saw_ack = 0; saw_en = 0;
    repeat (2) begin @(posedge clk); #1; if (o_ack) saw_ack = 1; end
    rst = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_ack) saw_ack = 1;
      if (o_ram_en) saw_en = 1;
    end
    chk("mid_no_ack", saw_ack, 0);
    chk("mid_no_en", saw_en, 0);

    // 256 corrections saturate the counter
    i_ram_dout = 12'hA7F;
    i_req = 1; i_we = 0; i_addr = 3'd3;
    nacks = 0; cyc = 0;
    while (nacks < 256 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (o_ack) begin
        nacks++;
        if (nacks == 1)   chk("sat_1", o_corr_count, 1);
        if (nacks == 254) chk("sat_254", o_corr_count, 254);
        if (nacks == 255) chk("sat_255", o_corr_count, 255);
        if (nacks == 256) chk("sat_256", o_corr_count, 255);
      end
    end
    i_req = 0;
    chk("sat_acks", nacks, 256);
    repeat (8) @(posedge clk);
    #1;
    chk("sat_final", o_corr_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
